// File: rtl/nmi_bus_arbiter.sv
// nmi_bus_arbiter
// Round-robin arbiter that shares one native-memory-interface slave port
// between NUM_MST masters. The grant is held for a whole transaction, until the
// slave answers with ready or the granted master withdraws its request.
// Optional feature: define NMI_ARB_TIMEOUT_EN to force an error completion
// (rdata 32'hDEAD_BEEF, sticky to_err_o) after TIMEOUT_CYC stalled BUSY cycles.
module nmi_bus_arbiter #(
  parameter int NUM_MST     = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_MST-1:0]              m_valid_i,
  input  logic [NUM_MST*ADDR_W-1:0]       m_addr_i,
  input  logic [NUM_MST*DATA_W-1:0]       m_wdata_i,
  input  logic [NUM_MST*(DATA_W/8)-1:0]   m_wstrb_i,
  output logic [NUM_MST-1:0]              m_ready_o,
  output logic [DATA_W-1:0]               m_rdata_o,
  output logic                            s_valid_o,
  output logic [ADDR_W-1:0]               s_addr_o,
  output logic [DATA_W-1:0]               s_wdata_o,
  output logic [DATA_W/8-1:0]             s_wstrb_o,
  input  logic                            s_ready_i,
  input  logic [DATA_W-1:0]               s_rdata_i,
  output logic [$clog2(NUM_MST)-1:0]      gnt_idx_o,
  output logic                            busy_o,
  output logic                            to_err_o,
  input  logic                            err_clr_i
);

  localparam int IDX_W  = $clog2(NUM_MST);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  gnt_q, gnt_d;

  logic              sel_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wstrb;

  // First requester found when scanning ptr, ptr+1, ... modulo NUM_MST.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_MST-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_MST; i++) begin
      idx = (int'(ptr) + i) % NUM_MST;
      if (!found && req[idx]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Round-robin successor of the master just served.
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
    return (g == IDX_W'(NUM_MST - 1)) ? '0 : g + 1'b1;
  endfunction

`ifdef NMI_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;
  logic        tmo_reached;
  logic        timeout_hit;
  logic        to_err_q;

  assign tmo_reached = (tmo_cnt_q == 16'(TIMEOUT_CYC - 1));
  assign to_err_o    = to_err_q;
`else
  // The timeout feature is compiled out: the clear input and the limit have no effect.
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  logic          unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign to_err_o       = 1'b0;
`endif

  assign gnt_idx_o = gnt_q;
  assign busy_o    = (state_q == ST_BUSY);

  // Mux the granted master's request fields toward the slave.
  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int k = 0; k < NUM_MST; k++) begin
      if (gnt_q == IDX_W'(k)) begin
        sel_valid = m_valid_i[k];
        sel_addr  = m_addr_i[k*ADDR_W +: ADDR_W];
        sel_wdata = m_wdata_i[k*DATA_W +: DATA_W];
        sel_wstrb = m_wstrb_i[k*STRB_W +: STRB_W];
      end
    end
  end

  // Next-state, grant and handshake outputs.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    s_valid_o = 1'b0;
    s_addr_o  = sel_addr;
    s_wdata_o = sel_wdata;
    s_wstrb_o = sel_wstrb;
    m_ready_o = '0;
    m_rdata_o = '0;
`ifdef NMI_ARB_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|m_valid_i) begin
          gnt_d   = rr_pick(m_valid_i, rr_ptr_q);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        s_valid_o = sel_valid;
        m_rdata_o = s_rdata_i;
        if (!sel_valid) begin
          // Granted master withdrew: abandon without ready, keep the pointer.
          state_d = ST_IDLE;
        end else if (s_ready_i) begin
          m_ready_o = NUM_MST'(1) << gnt_q;
          rr_ptr_d  = next_ptr(gnt_q);
          state_d   = ST_IDLE;
        end
`ifdef NMI_ARB_TIMEOUT_EN
        else if (tmo_reached) begin
          // Forced error completion; the slave request is withdrawn this cycle.
          s_valid_o   = 1'b0;
          m_ready_o   = NUM_MST'(1) << gnt_q;
          m_rdata_o   = DATA_W'(32'hDEAD_BEEF);
          rr_ptr_d    = next_ptr(gnt_q);
          state_d     = ST_IDLE;
          timeout_hit = 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, round-robin pointer and grant registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
    end
  end

`ifdef NMI_ARB_TIMEOUT_EN
  // Stall counter (zero on BUSY entry) and sticky timeout flag; set beats clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
      to_err_q  <= 1'b0;
    end else begin
      if (state_q == ST_IDLE) begin
        tmo_cnt_q <= '0;
      end else if (!s_ready_i) begin
        tmo_cnt_q <= tmo_cnt_q + 16'd1;
      end
      if (timeout_hit) begin
        to_err_q <= 1'b1;
      end else if (err_clr_i) begin
        to_err_q <= 1'b0;
      end
    end
  end
`endif

endmodule
